// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment driver showing a frame-sampled 8-bit value plus a halt marker.
// Define SEG_SCAN_DECIMAL_EN for a 3-digit decimal readout (double-dabble); hex readout otherwise.
module seg_scan_driver #(
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       halt,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
    localparam logic [6:0] GLYPH_H = 7'b0001001;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        unique case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [7:0]    snap;
    logic          upd;
    logic          tick;
    logic          frame_start;

    assign tick        = (cnt == LAST);
    assign frame_start = tick && (idx == 2'd3);

    // upd comes out of reset set so digit 0 is shown right after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            idx  <= '0;
            snap <= '0;
            upd  <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            upd <= tick;
            if (tick)
                idx <= idx + 2'd1;
            if (frame_start)
                snap <= value;
        end
    end

    logic [3:0] nib0, nib1, nib2;
    logic       blank1, blank2;

`ifdef SEG_SCAN_DECIMAL_EN
    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

    conv_state_t state, state_next;
    logic        conv_start;
    logic        load, shift, latch;
    logic [7:0]  bin_sh;
    logic [11:0] bcd_work;
    logic [11:0] bcd_latch;
    logic [7:0]  bcd_adj;
    logic [2:0]  iter;

    // Hundreds never exceeds 2 for an 8-bit input, so only ones/tens need the add-3 step.
    always_comb begin
        bcd_adj = bcd_work[7:0];
        for (int unsigned i = 0; i < 2; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        latch      = 1'b0;
        unique case (state)
            IDLE: begin
                if (conv_start) begin
                    load       = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                shift = 1'b1;
                if (iter == 3'd7)
                    state_next = DONE;
            end
            DONE: begin
                latch      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_start <= 1'b0;
            bin_sh     <= '0;
            bcd_work   <= '0;
            bcd_latch  <= '0;
            iter       <= '0;
        end else begin
            conv_start <= frame_start;
            if (load) begin
                bin_sh   <= snap;
                bcd_work <= '0;
                iter     <= '0;
            end else if (shift) begin
                bcd_work <= {bcd_work[10:8], bcd_adj, bin_sh[7]};
                bin_sh   <= {bin_sh[6:0], 1'b0};
                iter     <= iter + 3'd1;
            end
            if (latch)
                bcd_latch <= bcd_work;
        end
    end

    assign nib0   = bcd_latch[3:0];
    assign nib1   = bcd_latch[7:4];
    assign nib2   = bcd_latch[11:8];
    assign blank2 = (nib2 == 4'd0);
    assign blank1 = blank2 && (nib1 == 4'd0);
`else
    assign nib0   = snap[3:0];
    assign nib1   = snap[7:4];
    assign nib2   = '0;
    assign blank1 = 1'b0;
    assign blank2 = 1'b1;
`endif

    logic       blank;
    logic [6:0] glyph;

    always_comb begin
        blank = 1'b1;
        glyph = '1;
        unique case (idx)
            2'd0: begin
                blank = 1'b0;
                glyph = hex_glyph(nib0);
            end
            2'd1: begin
                blank = blank1;
                glyph = hex_glyph(nib1);
            end
            2'd2: begin
                blank = blank2;
                glyph = hex_glyph(nib2);
            end
            default: begin
                blank = !halt;
                glyph = GLYPH_H;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= '1;
        end else if (upd) begin
            an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
            seg <= blank ? 7'h7F : glyph;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random values/halt against a cycle-count reference model.
// Honours SEG_SCAN_DECIMAL_EN the same way the design does.
module tb_seg_scan_driver;

    localparam int R = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'hA5;
    logic       halt = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_driver #(.REFRESH_CYCLES(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .value(value),
        .halt (halt),
        .seg  (seg),
        .an   (an)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: edge k after release; digit d is shown from edge d*R+1 of each 4R-cycle frame,
    // the snapshot is taken on edges that are multiples of 4R.
    function automatic logic [11:0] model_disp(input int d, input logic [7:0] s,
                                               input logic [7:0] p, input logic h);
        logic       ok;
        logic       blank;
        logic [6:0] g;
        int         hund, tens, ones;
        ok    = 1'b1;
        blank = 1'b1;
        g     = 7'h7F;
        hund  = s / 100;
        tens  = (s / 10) % 10;
        ones  = s % 10;
        if (d == 3) begin
            blank = !h;
            g     = 7'b0001001;
        end else begin
`ifdef SEG_SCAN_DECIMAL_EN
            // the BCD latch lags a fresh snapshot, so only judge frames with a stable value
            ok = (s == p);
            case (d)
                0: begin blank = 1'b0; g = glyph_tab[ones]; end
                1: begin blank = (hund == 0) && (tens == 0); g = glyph_tab[tens]; end
                default: begin blank = (hund == 0); g = glyph_tab[hund]; end
            endcase
`else
            hund = p;
            case (d)
                0: begin blank = 1'b0; g = glyph_tab[s[3:0]]; end
                1: begin blank = 1'b0; g = glyph_tab[s[7:4]]; end
                default: blank = 1'b1;
            endcase
`endif
        end
        return {ok, blank ? 4'b1111 : ~(4'b0001 << d), blank ? 7'h7F : g};
    endfunction

    int         k;
    logic [7:0] snap_m, prev_m;
    logic       exp_ok;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= 0;
            snap_m  <= '0;
            prev_m  <= '0;
            exp_ok  <= 1'b1;
            exp_an  <= 4'b1111;
            exp_seg <= 7'h7F;
        end else begin
            k <= k + 1;
            if ((k + 1) % (4 * R) == 0) begin
                prev_m <= snap_m;
                snap_m <= value;
            end
            if ((k + 1) % R == 1)
                {exp_ok, exp_an, exp_seg} <= model_disp((k / R) % 4, snap_m, prev_m, halt);
        end
    end

    always @(negedge clk) begin
        if (!rst && exp_ok) begin
            check("an_model", 32'(an), 32'(exp_an));
            check("seg_model", 32'(seg), 32'(exp_seg));
        end
    end

    task automatic wait_slot(input int d, input int off);
        bit found = 1'b0;
        for (int i = 0; i < 4 * R + 5; i++) begin
            @(negedge clk);
            if (k % (4 * R) == d * R + off) begin
                found = 1'b1;
                break;
            end
        end
        if (!found)
            check("slot_timeout", 32'd0, 32'd1);
        #2;
    endtask

    task automatic check_digit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
        check({tag, "_an"}, 32'(an), 32'(e_an));
        check({tag, "_seg"}, 32'(seg), 32'(e_seg));
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_an"}, 32'(an), 32'(4'b1111));
        check({tag, "_seg"}, 32'(seg), 32'(7'h7F));
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic measure_period();
        int n = 0;
        int guard = 0;
        while (an == 4'b1110 && guard < 200) begin @(negedge clk); guard++; end
        while (an != 4'b1110 && guard < 200) begin @(negedge clk); guard++; end
        while (an == 4'b1110 && guard < 200) begin @(negedge clk); guard++; n++; end
        #2;
        check("digit_period", 32'(n), 32'(R));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        check_digit("reset_hold", 4'b1111, 7'h7F);
        @(negedge clk);
        rst = 1'b0;

        wait_slot(0, 5);
        check_digit("pre_snapshot_d0", 4'b1110, 7'b1000000);
        repeat (8 * R) @(negedge clk);

`ifndef SEG_SCAN_DECIMAL_EN
        wait_slot(0, 5); check_digit("a5_d0", 4'b1110, 7'b0010010);
        wait_slot(1, 5); check_digit("a5_d1", 4'b1101, 7'b0001000);
        wait_slot(2, 5); check_digit("a5_d2", 4'b1111, 7'h7F);
        wait_slot(3, 5); check_digit("a5_d3", 4'b1111, 7'h7F);
`endif

        halt = 1'b1;
        repeat (4 * R) @(negedge clk);
        wait_slot(3, 5); check_digit("halt_on", 4'b0111, 7'b0001001);
        wait_slot(1, 5); halt = 1'b0;
        wait_slot(3, 5); check_digit("halt_drop", 4'b1111, 7'h7F);

        value = 8'h12;
        repeat (8 * R) @(negedge clk);
        wait_slot(1, 5);
        value = 8'h34;
`ifndef SEG_SCAN_DECIMAL_EN
        wait_slot(1, 8); check_digit("snap_old_d1", 4'b1101, 7'b1111001);
        wait_slot(0, 5); check_digit("snap_new_d0", 4'b1110, 7'b0011001);
        wait_slot(1, 5); check_digit("snap_new_d1", 4'b1101, 7'b0110000);
`endif

`ifdef SEG_SCAN_DECIMAL_EN
        value = 8'd205;
        repeat (9 * R) @(negedge clk);
        wait_slot(0, 5); check_digit("dec205_d0", 4'b1110, 7'b0010010);
        wait_slot(1, 5); check_digit("dec205_d1", 4'b1101, 7'b1000000);
        wait_slot(2, 5); check_digit("dec205_d2", 4'b1011, 7'b0100100);
        value = 8'd7;
        repeat (9 * R) @(negedge clk);
        wait_slot(0, 5); check_digit("dec7_d0", 4'b1110, 7'b1111000);
        wait_slot(1, 5); check_digit("dec7_d1", 4'b1111, 7'h7F);
        wait_slot(2, 5); check_digit("dec7_d2", 4'b1111, 7'h7F);
        value = 8'd255;
        repeat (9 * R) @(negedge clk);
        wait_slot(0, 5); check_digit("dec255_d0", 4'b1110, 7'b0010010);
        wait_slot(1, 5); check_digit("dec255_d1", 4'b1101, 7'b0010010);
        wait_slot(2, 5); check_digit("dec255_d2", 4'b1011, 7'b0100100);
`else
        value = 8'hFF;
        repeat (9 * R) @(negedge clk);
        wait_slot(0, 5); check_digit("hexff_d0", 4'b1110, 7'b0001110);
        wait_slot(1, 5); check_digit("hexff_d1", 4'b1101, 7'b0001110);
`endif
        measure_period();

        wait_slot(2, 4);
        pulse_reset("rst_digit2");
        wait_slot(0, 5); check_digit("rst2_after_d0", 4'b1110, 7'b1000000);
        repeat (4 * R) @(negedge clk);
        wait_slot(0, 3);
        pulse_reset("rst_midconv");
        wait_slot(0, 5); check_digit("rstconv_after_d0", 4'b1110, 7'b1000000);

        for (int i = 0; i < 30; i++) begin
            value = 8'($urandom);
            halt  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(5, 90)) @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            value = 8'($urandom);
            repeat (9 * R) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
